uart_loader: RTL

Framed serial image loader between the UART receiver/transmitter and the RAM write port. It parses host frames (sync, 16-bit base address, length, payload, checksum) arriving as byte strobes from the UART. Each payload byte becomes a RAM write, and the block answers every frame with a single ACK/NAK byte. It owns CPU hold-in-reset and the `booting` mux select, and releases the CPU on a host GO byte.

---
 rtl/uart_loader_pkg.sv | 27 ++
 rtl/uart_loader_timeout.sv | 32 +++
 rtl/uart_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared protocol bytes and FSM state encoding for the serial image loader.
//   No ports. Exports LDR_* protocol constants and the loader state type.
package uart_loader_pkg;

    localparam logic [7:0] LDR_SYNC = 8'h55;
    localparam logic [7:0] LDR_GO   = 8'hAA;
    localparam logic [7:0] LDR_ACK  = 8'h06;
    localparam logic [7:0] LDR_NAK  = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_RESP,
        ST_GO
    } state_t;

    // States in which the inter-byte timeout is armed
    function automatic logic is_timed(state_t s);
        return s == ST_ADDR_HI || s == ST_ADDR_LO || s == ST_LEN || s == ST_DATA || s == ST_CSUM;
    endfunction

endpackage

// File: rtl/uart_loader_timeout.sv
// uart_loader_timeout: loadable down-counter flagging CYCLES idle cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : reload the counter (byte received or state change)
//   enable     : count while high
//   expired    : high on the cycle CYCLES after the last clear while enabled
module uart_loader_timeout #(
    parameter int unsigned CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    // Loaded with CYCLES-1 so that zero is reached exactly CYCLES cycles after the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= W'(CYCLES - 1);
        else if (enable && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = enable && cnt == '0;

endmodule

// File: rtl/uart_loader.sv
// uart_loader: framed serial image loader driving the RAM write port and CPU boot hold.
//   clk, rst_n         : clock, asynchronous active-low reset
//   rx_data, rx_done   : received byte and its one-cycle strobe
//   tx_done            : transmitter finished the response byte
//   trigger            : level; rising edge in IDLE starts a new load
//   tx_data, tx_wr     : response byte and one-cycle transmit request
//   ram_we/addr/data   : one-cycle RAM write
//   booting, cpu_rst   : loader owns RAM/UART, CPU held in reset
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter bit          BOOT_ON_RESET  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        tx_done,
    input  logic        trigger,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        booting,
    output logic        cpu_rst
);

    state_t      state, state_n;
    logic [15:0] base, base_n;
    logic [7:0]  len, len_n;
    logic [7:0]  idx, idx_n;
    logic [7:0]  csum, csum_n;
    logic [7:0]  sum;
    logic [7:0]  tx_data_n, ram_data_n;
    logic [15:0] ram_addr_n;
    logic        tx_wr_n, ram_we_n, booting_n;
    logic        trig_q;
    logic        expired;

    assign sum = csum + rx_data;

    uart_loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_done || state_n != state),
        .enable  (is_timed(state)),
        .expired (expired)
    );

    always_comb begin
        state_n    = state;
        base_n     = base;
        len_n      = len;
        idx_n      = idx;
        csum_n     = csum;
        tx_data_n  = tx_data;
        tx_wr_n    = 1'b0;
        ram_we_n   = 1'b0;
        ram_addr_n = ram_addr;
        ram_data_n = ram_data;
        case (state)
            ST_IDLE:
                if (trigger && !trig_q)
                    state_n = ST_SYNC;
            ST_SYNC:
                if (rx_done && rx_data == LDR_SYNC) begin
                    state_n = ST_ADDR_HI;
                    csum_n  = '0;
                    idx_n   = '0;
                end else if (rx_done && rx_data == LDR_GO) begin
                    state_n   = ST_GO;
                    tx_wr_n   = 1'b1;
                    tx_data_n = LDR_ACK;
                end
            ST_ADDR_HI:
                if (rx_done) begin
                    base_n[15:8] = rx_data;
                    csum_n       = sum;
                    state_n      = ST_ADDR_LO;
                end
            ST_ADDR_LO:
                if (rx_done) begin
                    base_n[7:0] = rx_data;
                    csum_n      = sum;
                    state_n     = ST_LEN;
                end
            ST_LEN:
                if (rx_done) begin
                    len_n   = rx_data;
                    csum_n  = sum;
                    state_n = ST_DATA;
                end
            ST_DATA:
                if (rx_done) begin
                    ram_we_n   = 1'b1;
                    ram_addr_n = base + 16'(idx);
                    ram_data_n = rx_data;
                    csum_n     = sum;
                    idx_n      = idx + 1'b1;
                    // len-1 wraps to 0xFF for len 0, giving a 256-byte payload
                    state_n    = idx == len - 1'b1 ? ST_CSUM : ST_DATA;
                end
            ST_CSUM:
                if (rx_done) begin
                    state_n   = ST_RESP;
                    tx_wr_n   = 1'b1;
                    tx_data_n = sum == 8'h00 ? LDR_ACK : LDR_NAK;
                end
            ST_RESP:
                if (tx_done)
                    state_n = ST_SYNC;
            ST_GO:
                if (tx_done)
                    state_n = ST_IDLE;
            default:
                state_n = ST_SYNC;
        endcase
        // A byte arriving on the expiry cycle takes priority over the timeout
        if (expired && !rx_done) begin
            state_n   = ST_RESP;
            tx_wr_n   = 1'b1;
            tx_data_n = LDR_NAK;
        end
        booting_n = state_n != ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT_ON_RESET ? ST_SYNC : ST_IDLE;
            base     <= '0;
            len      <= '0;
            idx      <= '0;
            csum     <= '0;
            tx_data  <= '0;
            tx_wr    <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            booting  <= BOOT_ON_RESET;
            cpu_rst  <= BOOT_ON_RESET;
            trig_q   <= 1'b0;
        end else begin
            state    <= state_n;
            base     <= base_n;
            len      <= len_n;
            idx      <= idx_n;
            csum     <= csum_n;
            tx_data  <= tx_data_n;
            tx_wr    <= tx_wr_n;
            ram_we   <= ram_we_n;
            ram_addr <= ram_addr_n;
            ram_data <= ram_data_n;
            booting  <= booting_n;
            cpu_rst  <= booting_n;
            trig_q   <= trigger;
        end
    end

endmodule
